unrotate: RTL
=============

# unrotate

Inverse rho-rotation stage for the Matrix Encoder datapath. It buffers a full 25x64 state that arrives slice by slice and undoes the per-lane rotation applied by the forward rotate stage. It then streams the restored state out slice by slice, in ascending z order. It sits on the decode side of the pipeline, between the slice source and the downstream inverse-permutation logic.

## Interface
Parameters:
- none; geometry is fixed at 25 lanes x 64 slices.

Ports:
- clk — input, 1 — sole clock; all state updates on the rising edge.
- rst — input, 1 — asynchronous, active-high reset.
- start — input, 1 — begins a frame; sampled only in IDLE.
- in_valid — input, 1 — in_slice holds a valid slice.
- in_ready — output, 1 — block accepts a slice this cycle.
- in_slice — input, 25 — slice z; bit i belongs to lane x=i%5, y=i/5.
- out_valid — output, 1 — out_slice holds a valid slice.
- out_ready — input, 1 — downstream accepts out_slice this cycle.
- out_slice — output, 25 — restored slice, bit i = lane i.
- busy — output, 1 — high in LOAD and DRAIN.
- done — output, 1 — one-cycle pulse after the last output transfer.
- bypass — input, 1 — present only with UNROTATE_BYPASS_EN; see Configuration.

## Operation
Offset table r_i, indexed by lane i = x+5y, i = 0..24:
- 0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14.

Storage:
- 25 lane registers of 64 bits each, plus a 7-bit slice counter cnt (0..64).

Load path:
- An input transfer happens when in_valid && in_ready.
- Input slices arrive implicitly in order z = cnt.
- On each transfer, bit i of in_slice is written to lane i at position (cnt − r_i) mod 64, using 6-bit wrap arithmetic.
- Net effect: out[i][z] = in[i][(z + r_i) mod 64].

Drain path:
- out_slice bit i = lane i at position cnt, read combinationally from the registered lanes.

FSM:
- IDLE: goes to LOAD when start=1; cnt := 0.
- LOAD: in_ready=1; cnt increments on each transfer; after the 64th transfer, goes to DRAIN with cnt := 0.
- DRAIN: out_valid=1; cnt increments on each out_valid && out_ready; after the 64th transfer, goes to DONE.
- DONE: done=1 for one cycle; goes to IDLE.

Boundary rules:
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored.
- out_slice is don't-care when out_valid=0.
- Wrap-around: position index is 6-bit modulo. Bit 2 (r=62) at z=0 is stored at position 2.
- Reset in any state: FSM returns to IDLE and cnt=0. Lane contents are not cleared; a new frame overwrites all 1600 bits.

## Timing
- Reset values: in_ready=0, out_valid=0, out_slice=0, busy=0, done=0.
- start sampled high in IDLE gives in_ready=1 on the next cycle.
- A slice accepted on cycle t is visible in the lanes at t+1.
- in_ready drops the cycle after the 64th transfer; out_valid rises on that same cycle.
- Input throughput is 1 slice/cycle with no bubbles when in_valid is held high.
- Output throughput is 1 slice/cycle while out_ready=1.
- out_slice and out_valid stay stable while out_ready=0.
- Minimum frame time is 1 + 64 + 64 + 1 = 130 cycles from start to IDLE.

## Configuration
- UNROTATE_BYPASS_EN defined:
  - Adds the bypass input port, sampled together with start in IDLE and latched for the whole frame.
  - When latched high, all r_i are treated as 0, so the block acts as a 64-slice store-and-forward buffer.
- UNROTATE_BYPASS_EN undefined:
  - The port is absent and the offset table is always applied.

## Test plan
- Single-bit lane 1 (r=1): in_slice=25'h2 at z=0, zeros elsewhere -> out_slice=25'h2 only at z=63, zero at all other z.
- Wrap case, lane 2 (r=62): 25'h4 at z=0 -> 25'h4 only at z=2; lane 0 (r=0) 25'h1 at z=5 -> 25'h1 at z=5.
- Round trip: random 1600-bit state forward-rotated by a reference model, then fed in -> output equals the original state for all 64 slices; done pulses once, 130 cycles after start with no stalls.
- Backpressure: out_ready toggled 1,0,0,1 during DRAIN -> out_slice held constant across stalls, no slice skipped or duplicated; in_valid gaps in LOAD -> cnt advances only on transfers.
- Reset mid-load: rst asserted after 30 input slices -> all outputs zero immediately, state IDLE; a new full frame then produces correct output.
- With UNROTATE_BYPASS_EN defined and bypass=1 at start: output slices equal input slices in the same order.

Source files
------------

// File: rtl/unrotate_if.sv
// unrotate_if: slice streams into and out of the unrotate stage.
// Handshake (both streams): a slice moves on a rising clk edge where valid
// and ready are both high. The producer holds valid and data steady until
// that transfer. Data is don't-care while valid is low.
interface unrotate_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;

  // Block-side view: consumes in_*, produces out_*.
  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice
  );

  // Environment-side view: produces in_*, consumes out_*.
  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice
  );
endinterface

// File: rtl/unrotate.sv
// unrotate: inverse rho-rotation stage for a 25-lane x 64-slice state.
// A frame is loaded slice by slice. Each lane bit is scattered to its
// un-rotated position as it arrives. The restored state is then drained in
// ascending z order.
// Optional build macro: UNROTATE_BYPASS_EN adds a 'bypass' input. It is
// latched at start, and when it is high all lane offsets are treated as zero.
module unrotate (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef UNROTATE_BYPASS_EN
  input  logic       bypass,
`endif
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state,
  unrotate_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] lane_q [25];
  logic [5:0]  wr_pos [25];
  logic [24:0] rd_slice;
  logic        load_fire;
  logic        drain_fire;
  logic        bypass_q;

  // Per-lane rotation offset r_i for lane i = x + 5y.
  function automatic logic [5:0] rot_of(input int unsigned lane);
    logic [5:0] r;
    case (lane)
      0:  r = 6'd0;
      1:  r = 6'd1;
      2:  r = 6'd62;
      3:  r = 6'd28;
      4:  r = 6'd27;
      5:  r = 6'd36;
      6:  r = 6'd44;
      7:  r = 6'd6;
      8:  r = 6'd55;
      9:  r = 6'd20;
      10: r = 6'd3;
      11: r = 6'd10;
      12: r = 6'd43;
      13: r = 6'd25;
      14: r = 6'd39;
      15: r = 6'd41;
      16: r = 6'd45;
      17: r = 6'd15;
      18: r = 6'd21;
      19: r = 6'd8;
      20: r = 6'd18;
      21: r = 6'd2;
      22: r = 6'd61;
      23: r = 6'd56;
      24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

`ifdef UNROTATE_BYPASS_EN
  // Capture the bypass request alongside start so it holds for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      bypass_q <= bypass;
    end
  end
`else
  assign bypass_q = 1'b0;
`endif

  assign load_fire  = bus.in_valid && in_ready_q;
  assign drain_fire = out_valid_q && bus.out_ready;

  // Write position for each lane: (cnt - r_i) mod 64, using natural 6-bit wrap.
  always_comb begin
    for (int i = 0; i < 25; i++) begin
      wr_pos[i] = cnt[5:0] - (bypass_q ? 6'd0 : rot_of(i));
    end
  end

  // Scatter each accepted slice into the lanes. The lanes have no reset because
  // every frame rewrites all 1600 bits.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int i = 0; i < 25; i++) begin
        lane_q[i][wr_pos[i]] <= bus.in_slice[i];
      end
    end
  end

  // Read slice cnt straight from the lanes, forced to zero when no slice is offered.
  always_comb begin
    rd_slice = '0;
    if (out_valid_q) begin
      for (int i = 0; i < 25; i++) begin
        rd_slice[i] = lane_q[i][cnt[5:0]];
      end
    end
  end

  // Frame sequencer: IDLE -> LOAD (64 in) -> DRAIN (64 out) -> DONE, with registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 7'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            cnt        <= 7'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            if (cnt == 7'd63) begin
              state       <= S_DRAIN;
              cnt         <= 7'd0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_fire) begin
            cnt <= cnt + 7'd1;
            if (cnt == 7'd63) begin
              state       <= S_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_slice = rd_slice;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fsm_state     = state;

endmodule
